// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the raw lines, deframes 11-bit frames,
// strips E0/F0 prefixes and holds the make code of the currently pressed key.
module ps2_kbd_rx #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT_CYC = 65000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] data,
   output logic [7:0] code,
   output logic       code_valid,
   output logic       ext,
   output logic       brk,
   output logic       frame_err
);

   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned CNT_W = 4;
   localparam logic [7:0]  EXT_CODE = 8'hE0;
   localparam logic [7:0]  BRK_CODE = 8'hF0;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK} state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_dat_sync;
   logic                   r_clk_prev;
   logic [CNT_W-1:0]       r_bit_cnt;
   logic [7:0]             r_shift;
   logic                   r_parity;
   logic                   r_stop;
   logic [TO_W-1:0]        r_to_cnt;
   logic                   r_ext_pend;
   logic                   r_brk_pend;
   logic [7:0]             r_data;
   logic [7:0]             r_code;
   logic                   r_code_valid;
   logic                   r_ext;
   logic                   r_brk;
   logic                   r_frame_err;

   logic w_clk_s;
   logic w_data_s;
   logic w_fall;
   logic w_last_bit;
   logic w_timeout;
   logic w_good;

   // Synchronisers idle high, matching the released open-collector lines
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clk_sync <= '1;
         r_dat_sync <= '1;
         r_clk_prev <= 1'b1;
      end else begin
         r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
         r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
         r_clk_prev <= w_clk_s;
      end
   end

   assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
   assign w_data_s   = r_dat_sync[SYNC_STAGES-1];
   assign w_fall     = r_clk_prev & ~w_clk_s;
   assign w_last_bit = w_fall & (r_bit_cnt == CNT_W'(9));
   // A fall in the expiry cycle takes priority over the timeout
   assign w_timeout  = (r_state == S_RECV) & ~w_fall & (r_to_cnt == TO_LAST);
   assign w_good     = (^{r_shift, r_parity}) & r_stop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_fall && !w_data_s) w_state_nxt = S_RECV;
         S_RECV: begin
            if (w_last_bit)     w_state_nxt = S_CHECK;
            else if (w_timeout) w_state_nxt = S_IDLE;
         end
         S_CHECK: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Frame datapath, prefix tracking and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_parity     <= 1'b0;
         r_stop       <= 1'b0;
         r_to_cnt     <= '0;
         r_ext_pend   <= 1'b0;
         r_brk_pend   <= 1'b0;
         r_data       <= '0;
         r_code       <= '0;
         r_code_valid <= 1'b0;
         r_ext        <= 1'b0;
         r_brk        <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_code_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_fall && !w_data_s) begin
                  r_bit_cnt <= '0;
                  r_to_cnt  <= '0;
               end
            end
            S_RECV: begin
               if (w_fall) begin
                  r_to_cnt  <= '0;
                  r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                  if (r_bit_cnt < CNT_W'(8))       r_shift  <= {w_data_s, r_shift[7:1]};
                  else if (r_bit_cnt == CNT_W'(8)) r_parity <= w_data_s;
                  else                             r_stop   <= w_data_s;
               end else if (w_timeout) begin
                  r_frame_err <= 1'b1;
                  r_ext_pend  <= 1'b0;
                  r_brk_pend  <= 1'b0;
               end else begin
                  r_to_cnt <= r_to_cnt + TO_W'(1);
               end
            end
            S_CHECK: begin
               if (!w_good) begin
                  r_frame_err <= 1'b1;
                  r_ext_pend  <= 1'b0;
                  r_brk_pend  <= 1'b0;
               end else if (r_shift == EXT_CODE) begin
                  r_ext_pend <= 1'b1;
               end else if (r_shift == BRK_CODE) begin
                  r_brk_pend <= 1'b1;
               end else begin
                  r_code       <= r_shift;
                  r_ext        <= r_ext_pend;
                  r_brk        <= r_brk_pend;
                  r_code_valid <= 1'b1;
                  r_ext_pend   <= 1'b0;
                  r_brk_pend   <= 1'b0;
                  // Only releasing the held key clears it
                  if (!r_brk_pend)             r_data <= r_shift;
                  else if (r_shift == r_data)  r_data <= 8'h00;
               end
            end
            default: ;
         endcase
      end
   end

   assign data       = r_data;
   assign code       = r_code;
   assign code_valid = r_code_valid;
   assign ext        = r_ext;
   assign brk        = r_brk;
   assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed self-checking bench for ps2_kbd_rx: frames, prefixes, errors,
// timeout, reset mid-frame and back-to-back frames.
module tb_ps2_kbd_rx;

   localparam int HALF = 20;
   localparam int GAP  = 60;
   localparam int TO   = 300;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] data;
   logic [7:0] code;
   logic       code_valid;
   logic       ext;
   logic       brk;
   logic       frame_err;

   int n_chk  = 0;
   int n_pass = 0;
   int cv_cnt = 0;
   int err_cnt = 0;

   ps2_kbd_rx #(.SYNC_STAGES(2), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .data(data), .code(code), .code_valid(code_valid), .ext(ext),
      .brk(brk), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // Count strobe-high cycles so a stuck or double pulse shows up as >1
   always @(negedge clk) begin
      if (code_valid === 1'b1) cv_cnt++;
      if (frame_err === 1'b1) err_cnt++;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
   endfunction

   task automatic half_wait();
      repeat (HALF) @(posedge clk);
      #1;
   endtask

   task automatic idle_gap();
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (GAP) @(posedge clk);
      #1;
   endtask

   // Drives bits f[0..n-1]; with hold_low it returns right after the last fall
   task automatic send_bits(input logic [10:0] f, input int n, input bit hold_low);
      for (int i = 0; i < n; i++) begin
         ps2_data = f[i];
         half_wait();
         ps2_clk = 1'b0;
         if (hold_low && i == n - 1) return;
         half_wait();
         ps2_clk = 1'b1;
      end
      idle_gap();
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_bits(mk_frame(b, 1'b0, 1'b0), 11, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      n_chk++; if (data !== 8'h00) $display("FAIL reset_data got=%h exp=00", data); else n_pass++;
      n_chk++; if (code !== 8'h00) $display("FAIL reset_code got=%h exp=00", code); else n_pass++;
      n_chk++; if ({code_valid, ext, brk, frame_err} !== 4'b0000)
         $display("FAIL reset_flags got=%b exp=0000", {code_valid, ext, brk, frame_err}); else n_pass++;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_make();
      int base;
      base = cv_cnt;
      send_bits(mk_frame(8'h72, 1'b0, 1'b0), 11, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      n_chk++; if (code_valid !== 1'b0) $display("FAIL make_lat_early got=%b exp=0", code_valid); else n_pass++;
      @(posedge clk); #1;
      n_chk++; if (code_valid !== 1'b1) $display("FAIL make_lat_strobe got=%b exp=1", code_valid); else n_pass++;
      n_chk++; if (code !== 8'h72) $display("FAIL make_code got=%h exp=72", code); else n_pass++;
      n_chk++; if ({ext, brk} !== 2'b00) $display("FAIL make_extbrk got=%b exp=00", {ext, brk}); else n_pass++;
      n_chk++; if (data !== 8'h72) $display("FAIL make_data got=%h exp=72", data); else n_pass++;
      @(posedge clk); #1;
      n_chk++; if (code_valid !== 1'b0) $display("FAIL make_one_cycle got=%b exp=0", code_valid); else n_pass++;
      idle_gap();
      n_chk++; if (cv_cnt - base !== 1) $display("FAIL make_strobes got=%0d exp=1", cv_cnt - base); else n_pass++;
   endtask

   task automatic test_ext_seq();
      int base;
      base = cv_cnt;
      send_byte(8'hE0);
      send_byte(8'h75);
      n_chk++; if (cv_cnt - base !== 1) $display("FAIL ext_make_strobes got=%0d exp=1", cv_cnt - base); else n_pass++;
      n_chk++; if ({code, ext, brk} !== {8'h75, 2'b10}) $display("FAIL ext_make_out got=%h/%b%b exp=75/10", code, ext, brk); else n_pass++;
      n_chk++; if (data !== 8'h75) $display("FAIL ext_make_data got=%h exp=75", data); else n_pass++;
      base = cv_cnt;
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h75);
      n_chk++; if (cv_cnt - base !== 1) $display("FAIL ext_brk_strobes got=%0d exp=1", cv_cnt - base); else n_pass++;
      n_chk++; if ({code, ext, brk} !== {8'h75, 2'b11}) $display("FAIL ext_brk_out got=%h/%b%b exp=75/11", code, ext, brk); else n_pass++;
      n_chk++; if (data !== 8'h00) $display("FAIL ext_brk_data got=%h exp=00", data); else n_pass++;
   endtask

   task automatic test_release_other();
      int base;
      send_byte(8'h72);
      base = cv_cnt;
      send_byte(8'hF0);
      send_byte(8'h75);
      n_chk++; if (cv_cnt - base !== 1) $display("FAIL rel_other_strobes got=%0d exp=1", cv_cnt - base); else n_pass++;
      n_chk++; if ({code, ext, brk} !== {8'h75, 2'b01}) $display("FAIL rel_other_out got=%h/%b%b exp=75/01", code, ext, brk); else n_pass++;
      n_chk++; if (data !== 8'h72) $display("FAIL rel_other_data got=%h exp=72", data); else n_pass++;
   endtask

   task automatic test_bad_frames();
      int bcv, berr;
      bcv = cv_cnt; berr = err_cnt;
      send_bits(mk_frame(8'h72, 1'b1, 1'b0), 11, 1'b0);
      n_chk++; if (err_cnt - berr !== 1) $display("FAIL bad_par_err got=%0d exp=1", err_cnt - berr); else n_pass++;
      n_chk++; if (cv_cnt - bcv !== 0) $display("FAIL bad_par_cv got=%0d exp=0", cv_cnt - bcv); else n_pass++;
      n_chk++; if ({data, code} !== {8'h72, 8'h75}) $display("FAIL bad_par_hold got=%h/%h exp=72/75", data, code); else n_pass++;
      send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11, 1'b0);
      n_chk++; if (err_cnt - berr !== 2) $display("FAIL bad_stop_err got=%0d exp=2", err_cnt - berr); else n_pass++;
      n_chk++; if (cv_cnt - bcv !== 0) $display("FAIL bad_stop_cv got=%0d exp=0", cv_cnt - bcv); else n_pass++;
      n_chk++; if ({data, code, brk} !== {8'h72, 8'h75, 1'b1}) $display("FAIL bad_stop_hold got=%h/%h/%b exp=72/75/1", data, code, brk); else n_pass++;
      send_byte(8'hF0);
      send_bits(mk_frame(8'h33, 1'b1, 1'b0), 11, 1'b0);
      send_byte(8'h72);
      n_chk++; if ({brk, data} !== {1'b0, 8'h72}) $display("FAIL bad_clears_pend got=%b/%h exp=0/72", brk, data); else n_pass++;
   endtask

   task automatic test_timeout();
      int berr, got;
      send_byte(8'hE0);
      berr = err_cnt;
      got = 0;
      send_bits(mk_frame(8'h33, 1'b0, 1'b0), 5, 1'b1);
      for (int c = 1; c <= TO + 50; c++) begin
         @(posedge clk); #1;
         if (c == HALF) ps2_clk = 1'b1;
         if (frame_err === 1'b1) begin
            got = c;
            break;
         end
      end
      n_chk++; if (got < TO + 2 || got > TO + 5) $display("FAIL timeout_latency got=%0d exp=%0d..%0d", got, TO + 2, TO + 5); else n_pass++;
      @(posedge clk); #1;
      n_chk++; if (frame_err !== 1'b0) $display("FAIL timeout_one_cycle got=%b exp=0", frame_err); else n_pass++;
      idle_gap();
      send_byte(8'h1C);
      n_chk++; if ({code, ext, brk} !== {8'h1C, 2'b00}) $display("FAIL timeout_next_out got=%h/%b%b exp=1C/00", code, ext, brk); else n_pass++;
      n_chk++; if (data !== 8'h1C) $display("FAIL timeout_next_data got=%h exp=1C", data); else n_pass++;
      n_chk++; if (err_cnt - berr !== 1) $display("FAIL timeout_err_count got=%0d exp=1", err_cnt - berr); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int bcv, berr;
      send_bits(mk_frame(8'h72, 1'b0, 1'b0), 6, 1'b0);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++; if ({data, code} !== 16'h0000) $display("FAIL rst_mid_out got=%h/%h exp=00/00", data, code); else n_pass++;
      n_chk++; if ({code_valid, ext, brk, frame_err} !== 4'b0000)
         $display("FAIL rst_mid_flags got=%b exp=0000", {code_valid, ext, brk, frame_err}); else n_pass++;
      rst_n = 1'b1;
      idle_gap();
      bcv = cv_cnt; berr = err_cnt;
      ps2_data = 1'b1;
      half_wait();
      ps2_clk = 1'b0;
      half_wait();
      idle_gap();
      send_byte(8'h72);
      n_chk++; if (cv_cnt - bcv !== 1) $display("FAIL rst_mid_strobes got=%0d exp=1", cv_cnt - bcv); else n_pass++;
      n_chk++; if (err_cnt - berr !== 0) $display("FAIL rst_mid_err got=%0d exp=0", err_cnt - berr); else n_pass++;
      n_chk++; if ({code, data} !== {8'h72, 8'h72}) $display("FAIL rst_mid_decode got=%h/%h exp=72/72", code, data); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int bcv, berr;
      logic [10:0] f2;
      bcv = cv_cnt; berr = err_cnt;
      f2 = mk_frame(8'h1C, 1'b0, 1'b0);
      send_bits(mk_frame(8'h72, 1'b0, 1'b0), 11, 1'b1);
      // Start-bit fall timed to be detected in the first IDLE cycle after CHECK
      @(posedge clk); #1;
      ps2_clk = 1'b1;
      ps2_data = 1'b0;
      @(posedge clk); #1;
      ps2_clk = 1'b0;
      half_wait();
      ps2_clk = 1'b1;
      send_bits(11'(f2 >> 1), 10, 1'b0);
      n_chk++; if (cv_cnt - bcv !== 2) $display("FAIL b2b_strobes got=%0d exp=2", cv_cnt - bcv); else n_pass++;
      n_chk++; if (err_cnt - berr !== 0) $display("FAIL b2b_err got=%0d exp=0", err_cnt - berr); else n_pass++;
      n_chk++; if ({code, data} !== {8'h1C, 8'h1C}) $display("FAIL b2b_decode got=%h/%h exp=1C/1C", code, data); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_make();
      test_ext_seq();
      test_release_other();
      test_bad_frames();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
